// File: rtl/jump_control.sv
`default_nettype none
// ============================================================================
// Module   : jump_control
// Purpose  : JR/JAL/J decode, return-address stack and a registered PC
//            redirect over valid/ready, followed by a configurable flush.
// Revision : 1.0 - initial release
// ============================================================================
module jump_control #(
  parameter int ADDR_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 2,
  parameter int FUNC_WIDTH   = 4,
  parameter logic [OPCODE_WIDTH+FUNC_WIDTH-1:0] JR_CODE = 6'b001000,
  parameter int RAS_DEPTH    = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            instr_valid,
  input  logic [OPCODE_WIDTH-1:0]         ula_opcode,
  input  logic [FUNC_WIDTH-1:0]           func,
  input  logic                            is_jal,
  input  logic                            is_j,
  input  logic [ADDR_WIDTH-1:0]           pc_plus4,
  input  logic [ADDR_WIDTH-1:0]           jump_target,
  input  logic [ADDR_WIDTH-1:0]           rs_value,
  output logic                            JR_control,
  output logic                            stall,
  output logic                            redirect_valid,
  input  logic                            redirect_ready,
  output logic [ADDR_WIDTH-1:0]           redirect_pc,
  output logic                            flush,
  output logic [$clog2(RAS_DEPTH+1)-1:0]  ras_count,
  output logic                            ras_hit,
  output logic                            ras_mispredict,
  output logic                            ras_overflow,
  output logic                            ras_underflow
);

  localparam int PTR_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W  = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int RCNT_W = $clog2(RAS_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   ras_q [RAS_DEPTH];
  logic [ADDR_WIDTH-1:0]   ras_d [RAS_DEPTH];
  logic [PTR_W-1:0]        top_q, top_d;
  logic [RCNT_W-1:0]       count_q, count_d;
  logic                    hit_q, hit_d;
  logic                    mis_q, mis_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;

  logic                    code_is_jr;
  logic                    accept;
  logic                    take_jr;
  logic                    take_jal;
  logic [PTR_W-1:0]        top_inc;
  logic [PTR_W-1:0]        top_dec;
  logic                    ras_full;
  logic                    ras_empty;

  // Decode and acceptance; JR wins over JAL, which wins over J
  assign code_is_jr = ({ula_opcode, func} == JR_CODE);
  assign JR_control = instr_valid && code_is_jr;
  assign accept     = (state_q == IDLE) && instr_valid && (code_is_jr || is_jal || is_j);
  assign take_jr    = accept && code_is_jr;
  assign take_jal   = accept && !code_is_jr && is_jal;

  // Circular top pointer wraps modulo RAS_DEPTH in both directions
  assign top_inc   = (top_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_q + PTR_W'(1);
  assign top_dec   = (top_q == '0) ? PTR_W'(RAS_DEPTH - 1) : top_q - PTR_W'(1);
  assign ras_full  = (count_q == RCNT_W'(RAS_DEPTH));
  assign ras_empty = (count_q == '0);

  // Next-state logic for the redirect/flush sequencer and latched target
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = REDIRECT;
          pc_d    = code_is_jr ? rs_value : jump_target;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          if (FLUSH_CYCLES > 0) begin
            state_d = FLUSH;
            cnt_d   = CNT_W'(FLUSH_CYCLES);
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Return-address stack update and status pulses for the accepted jump
  always_comb begin
    ras_d   = ras_q;
    top_d   = top_q;
    count_d = count_q;
    hit_d   = 1'b0;
    mis_d   = 1'b0;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (take_jal) begin
      // When full, the slot after the top holds the oldest entry
      ras_d[top_inc] = pc_plus4;
      top_d          = top_inc;
      if (ras_full) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + RCNT_W'(1);
      end
    end else if (take_jr) begin
      if (ras_empty) begin
        unf_d = 1'b1;
      end else begin
        hit_d   = (rs_value == ras_q[top_q]);
        mis_d   = (rs_value != ras_q[top_q]);
        top_d   = top_dec;
        count_d = count_q - RCNT_W'(1);
      end
    end
  end

  // State and RAS registers with asynchronous clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      top_q   <= '0;
      count_q <= '0;
      hit_q   <= 1'b0;
      mis_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      top_q   <= top_d;
      count_q <= count_d;
      hit_q   <= hit_d;
      mis_q   <= mis_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= ras_d[i];
      end
    end
  end

  assign stall          = (state_q != IDLE);
  assign redirect_valid = (state_q == REDIRECT);
  assign flush          = (state_q == FLUSH);
  assign redirect_pc    = pc_q;
  assign ras_count      = count_q;
  assign ras_hit        = hit_q;
  assign ras_mispredict = mis_q;
  assign ras_overflow   = ovf_q;
  assign ras_underflow  = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_jump_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_jump_control
// Purpose  : Self-checking bench for jump_control: directed scenarios plus
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jump_control;

  localparam int FLUSH_A = 2;
  localparam int DEPTH   = 4;
  localparam logic [5:0] JR = 6'b001000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid, is_jal, is_j, redirect_ready;
  logic [5:0]  code;
  logic [31:0] pc_plus4, jump_target, rs_value;
  logic        b_valid, b_ready;

  logic        jr_c, stall, rv, flush, hit, mis, ovf, unf;
  logic [31:0] rpc;
  logic [2:0]  cnt;
  logic        b_jr, b_st, b_rv, b_fl, b_hit, b_mis, b_ovf, b_unf;
  logic [31:0] b_pc;
  logic [2:0]  b_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: a queue-based RAS and a simple busy description
  bit          m_rv;
  logic [31:0] m_pc;
  int          m_fl;
  logic [31:0] m_ras[$];
  bit          m_hit, m_mis, m_ovf, m_unf;

  always #5 clock = ~clock;

  jump_control #(.ADDR_WIDTH(32), .OPCODE_WIDTH(2), .FUNC_WIDTH(4), .JR_CODE(JR),
                 .RAS_DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_A)) u_dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid),
    .ula_opcode(code[5:4]), .func(code[3:0]), .is_jal(is_jal), .is_j(is_j),
    .pc_plus4(pc_plus4), .jump_target(jump_target), .rs_value(rs_value),
    .JR_control(jr_c), .stall(stall), .redirect_valid(rv),
    .redirect_ready(redirect_ready), .redirect_pc(rpc), .flush(flush),
    .ras_count(cnt), .ras_hit(hit), .ras_mispredict(mis),
    .ras_overflow(ovf), .ras_underflow(unf));

  jump_control #(.ADDR_WIDTH(32), .OPCODE_WIDTH(2), .FUNC_WIDTH(4), .JR_CODE(JR),
                 .RAS_DEPTH(DEPTH), .FLUSH_CYCLES(0)) u_dut_nf (
    .clock(clock), .reset(reset), .instr_valid(b_valid),
    .ula_opcode(code[5:4]), .func(code[3:0]), .is_jal(is_jal), .is_j(is_j),
    .pc_plus4(pc_plus4), .jump_target(jump_target), .rs_value(rs_value),
    .JR_control(b_jr), .stall(b_st), .redirect_valid(b_rv),
    .redirect_ready(b_ready), .redirect_pc(b_pc), .flush(b_fl),
    .ras_count(b_cnt), .ras_hit(b_hit), .ras_mispredict(b_mis),
    .ras_overflow(b_ovf), .ras_underflow(b_unf));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rv = 0; m_pc = '0; m_fl = 0; m_ras.delete();
    m_hit = 0; m_mis = 0; m_ovf = 0; m_unf = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs seen at the edge
  task automatic model_edge();
    m_hit = 0; m_mis = 0; m_ovf = 0; m_unf = 0;
    if (m_rv) begin
      if (redirect_ready) begin
        m_rv = 0;
        m_fl = FLUSH_A;
      end
    end else if (m_fl > 0) begin
      m_fl--;
    end else if (instr_valid && (code == JR || is_jal || is_j)) begin
      m_rv = 1;
      if (code == JR) begin
        m_pc = rs_value;
        if (m_ras.size() == 0) m_unf = 1;
        else begin
          if (rs_value == m_ras[$]) m_hit = 1; else m_mis = 1;
          void'(m_ras.pop_back());
        end
      end else if (is_jal) begin
        m_pc = jump_target;
        if (m_ras.size() == DEPTH) begin
          m_ovf = 1;
          void'(m_ras.pop_front());
        end
        m_ras.push_back(pc_plus4);
      end else begin
        m_pc = jump_target;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rv"},    rv,    m_rv);
    check({tag, ".pc"},    rpc,   m_pc);
    check({tag, ".flush"}, flush, (m_fl > 0));
    check({tag, ".stall"}, stall, (m_rv || m_fl > 0));
    check({tag, ".cnt"},   cnt,   m_ras.size());
    check({tag, ".hit"},   hit,   m_hit);
    check({tag, ".mis"},   mis,   m_mis);
    check({tag, ".ovf"},   ovf,   m_ovf);
    check({tag, ".unf"},   unf,   m_unf);
    check({tag, ".jrc"},   jr_c,  (instr_valid && code == JR));
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic [5:0] c, input logic jal, input logic j,
                        input logic [31:0] p4, input logic [31:0] tgt, input logic [31:0] rs);
    code = c; is_jal = jal; is_j = j; pc_plus4 = p4; jump_target = tgt; rs_value = rs;
  endtask

  // Present a jump for one edge; afterwards the bench sits in the first REDIRECT cycle
  task automatic issue(input string tag, input logic [5:0] c, input logic jal, input logic j,
                       input logic [31:0] p4, input logic [31:0] tgt, input logic [31:0] rs);
    set_in(c, jal, j, p4, tgt, rs);
    instr_valid = 1; redirect_ready = 0;
    step(tag);
    instr_valid = 0;
    check({tag, ".acc"}, rv, 1'b1);
  endtask

  // Handshake, then walk the flush window and land in IDLE
  task automatic finish_jump(input string tag);
    redirect_ready = 1;
    step({tag, ".hs"});
    redirect_ready = 0;
    for (int i = 0; i < FLUSH_A; i++) begin
      check({tag, ".fl_on"}, flush, 1'b1);
      if (i < FLUSH_A - 1) step({tag, ".fl"});
    end
    step({tag, ".idle"});
    check({tag, ".fl_off"}, flush, 1'b0);
    check({tag, ".st_off"}, stall, 1'b0);
  endtask

  task automatic async_reset(input string tag);
    #3 reset = 1;
    #1;
    model_reset();
    check_all(tag);
    check({tag, ".b_rv"}, b_rv, 1'b0);
    @(negedge clock);
    reset = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    instr_valid = 0; redirect_ready = 0; b_valid = 0; b_ready = 0;
    set_in(6'd0, 0, 0, '0, '0, '0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all("rst");
    @(negedge clock);
    reset = 0;

    // Reset in the middle of a stalled redirect
    issue("j40", 6'd0, 0, 1, 32'h0, 32'h40, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step("j40.hold");
      check("j40.rv", rv, 1'b1);
      check("j40.pc", rpc, 32'h40);
    end
    async_reset("rst_mid");

    // JAL then JR hit
    issue("jal104", 6'd0, 1, 0, 32'h104, 32'h500, 32'h0);
    check("jal104.cnt", cnt, 3'd1);
    finish_jump("jal104");
    issue("jr104", JR, 0, 0, 32'h0, 32'h0, 32'h104);
    check("jr104.hit", hit, 1'b1);
    check("jr104.pc", rpc, 32'h104);
    check("jr104.cnt", cnt, 3'd0);
    finish_jump("jr104");

    // Mispredict then underflow
    issue("jal200", 6'd0, 1, 0, 32'h200, 32'h600, 32'h0);
    finish_jump("jal200");
    issue("jr300", JR, 0, 0, 32'h0, 32'h0, 32'h300);
    check("jr300.mis", mis, 1'b1);
    check("jr300.pc", rpc, 32'h300);
    finish_jump("jr300");
    issue("jr_unf", JR, 0, 0, 32'h0, 32'h0, 32'h300);
    check("jr_unf.unf", unf, 1'b1);
    check("jr_unf.cnt", cnt, 3'd0);
    finish_jump("jr_unf");

    // Overflow and wrap
    for (int i = 1; i <= 5; i++) begin
      issue("jal_ovf", 6'd0, 1, 0, 32'(i * 16), 32'h700, 32'h0);
      check("jal_ovf.ovf", ovf, (i == 5));
      finish_jump("jal_ovf");
    end
    check("ovf.cnt", cnt, 3'd4);
    for (int i = 5; i >= 1; i--) begin
      issue("jr_wrap", JR, 0, 0, 32'h0, 32'h0, 32'(i * 16));
      check("jr_wrap.hit", hit, (i >= 2));
      check("jr_wrap.unf", unf, (i == 1));
      finish_jump("jr_wrap");
    end

    // Priority: JR code together with JAL and J
    issue("jal77", 6'd0, 1, 0, 32'h77, 32'h800, 32'h0);
    finish_jump("jal77");
    issue("prio", JR, 1, 1, 32'h999, 32'h900, 32'h77);
    check("prio.hit", hit, 1'b1);
    check("prio.pc", rpc, 32'h77);
    check("prio.cnt", cnt, 3'd0);
    finish_jump("prio");

    // Near-miss code is not JR and causes no redirect
    set_in(6'b001001, 0, 0, 32'h0, 32'h0, 32'h123);
    instr_valid = 1;
    #1;
    check("nojr.jrc", jr_c, 1'b0);
    step("nojr");
    check("nojr.rv", rv, 1'b0);
    instr_valid = 0;

    // A held J is ignored while busy and taken on the first IDLE edge
    issue("j_a", 6'd0, 0, 1, 32'h0, 32'h40, 32'h0);
    set_in(6'd0, 0, 1, 32'h0, 32'h60, 32'h0);
    instr_valid = 1;
    step("busy.r");
    check("busy.pc", rpc, 32'h40);
    redirect_ready = 1;
    step("busy.hs");
    redirect_ready = 0;
    for (int i = 0; i < FLUSH_A - 1; i++) step("busy.fl");
    check("busy.st", stall, 1'b1);
    step("busy.idle");
    check("busy.idle_rv", rv, 1'b0);
    check("busy.idle_st", stall, 1'b0);
    step("busy.acc");
    instr_valid = 0;
    check("busy.acc_rv", rv, 1'b1);
    check("busy.acc_pc", rpc, 32'h60);
    finish_jump("busy");

    // Zero flush cycles: back to IDLE straight after the handshake
    set_in(6'd0, 0, 1, 32'h0, 32'h80, 32'h0);
    b_valid = 1;
    step("nf.acc");
    check("nf.rv", b_rv, 1'b1);
    check("nf.pc", b_pc, 32'h80);
    check("nf.st", b_st, 1'b1);
    b_ready = 1;
    step("nf.hs");
    check("nf.hs_rv", b_rv, 1'b0);
    check("nf.hs_fl", b_fl, 1'b0);
    check("nf.hs_st", b_st, 1'b0);
    jump_target = 32'h90;
    b_ready = 0;
    step("nf.acc2");
    check("nf.rv2", b_rv, 1'b1);
    check("nf.pc2", b_pc, 32'h90);
    b_valid = 0;
    b_ready = 1;
    step("nf.hs2");
    check("nf.hs2_fl", b_fl, 1'b0);
    b_ready = 0;

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel = $urandom_range(0, 5);
      code = (sel <= 1) ? JR : (sel == 2) ? 6'b001001 : 6'($urandom);
      is_jal = ($urandom_range(0, 2) == 0);
      is_j = ($urandom_range(0, 2) == 0);
      pc_plus4 = $urandom;
      jump_target = $urandom;
      rs_value = (m_ras.size() > 0 && $urandom_range(0, 1) == 1) ? m_ras[$] : $urandom;
      instr_valid = ($urandom_range(0, 3) != 0);
      redirect_ready = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 299) == 0) async_reset("rnd_rst");
      else step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
